// File: rtl/mem_stage_pkg.sv
// Shared codes for the memory stage: access-width/sign encodings, exception codes,
// FSM states and small helpers that decode an access into size and byte enables.
package mem_stage_pkg;

    localparam logic [2:0] MEM_OP_B  = 3'b000;
    localparam logic [2:0] MEM_OP_H  = 3'b001;
    localparam logic [2:0] MEM_OP_W  = 3'b010;
    localparam logic [2:0] MEM_OP_BU = 3'b100;
    localparam logic [2:0] MEM_OP_HU = 3'b101;

    localparam logic [1:0] EXC_NONE      = 2'b00;
    localparam logic [1:0] EXC_MISALIGN  = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT   = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL   = 2'b11;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    // Unassigned op codes fall through to a full-word access.
    function automatic size_e op_size(input logic [2:0] op);
        case (op)
            MEM_OP_B, MEM_OP_BU: op_size = SIZE_B;
            MEM_OP_H, MEM_OP_HU: op_size = SIZE_H;
            default:             op_size = SIZE_W;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] off);
        case (sz)
            SIZE_B:  byte_en = 4'b0001 << off;
            SIZE_H:  byte_en = 4'b0011 << off;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SIZE_H:  misaligned = off[0];
            SIZE_W:  misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Picks the addressed byte/halfword lane out of a read word and sign- or
// zero-extends it to 32 bits; full-word reads pass through unchanged.
module mem_stage_load_extend
    import mem_stage_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] ext_data
);

    logic [31:0] shifted;
    logic        is_signed;

    assign shifted   = rdata >> {addr, 3'b000};
    assign is_signed = ~mem_op[2];

    always_comb begin
        ext_data = rdata;
        case (op_size(mem_op))
            SIZE_B:  ext_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            SIZE_H:  ext_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: registers pass-through results, runs one outstanding req/ack
// bus transaction per load/store and reports misalignment, illegal ops and timeouts.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       C,
    input  logic [31:0]       rf_rD2,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        mem_op,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic [1:0]        out_exc
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e             state_q;
    logic [7:0]         cnt_q;
    logic [31:0]        c_q;
    logic [2:0]         op_q;
    logic               bus_req_q;
    logic               bus_we_q;
    logic [ADDR_W-1:0]  bus_addr_q;
    logic [3:0]         bus_be_q;
    logic [31:0]        bus_wdata_q;
    logic               out_valid_q;
    logic [31:0]        out_data_q;
    logic [1:0]         out_exc_q;

    size_e              in_size;
    logic [31:0]        store_data;
    logic [31:0]        load_data;

    assign in_size = op_size(mem_op);

    always_comb begin
        case (in_size)
            SIZE_B:  store_data = {4{rf_rD2[7:0]}};
            SIZE_H:  store_data = {2{rf_rD2[15:0]}};
            default: store_data = rf_rD2;
        endcase
    end

    // Lane select uses the latched address since bus_addr drops the low bits.
    mem_stage_load_extend u_load_extend (
        .mem_op   (op_q),
        .addr     (c_q[1:0]),
        .rdata    (bus_rdata),
        .ext_data (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STATE_IDLE;
            cnt_q       <= '0;
            c_q         <= '0;
            op_q        <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_exc_q   <= EXC_NONE;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                STATE_IDLE: begin
                    if (in_valid) begin
                        if (mem_rd && mem_wr) begin
                            out_valid_q <= 1'b1;
                            out_exc_q   <= EXC_ILLEGAL;
                            out_data_q  <= '0;
                        end else if (!mem_rd && !mem_wr) begin
                            out_valid_q <= 1'b1;
                            out_exc_q   <= EXC_NONE;
                            out_data_q  <= C;
                        end else if (misaligned(in_size, C[1:0])) begin
                            out_valid_q <= 1'b1;
                            out_exc_q   <= EXC_MISALIGN;
                            out_data_q  <= C;
                        end else begin
                            state_q     <= STATE_WAIT;
                            cnt_q       <= '0;
                            c_q         <= C;
                            op_q        <= mem_op;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= mem_wr;
                            bus_addr_q  <= {C[ADDR_W-1:2], 2'b00};
                            bus_be_q    <= byte_en(in_size, C[1:0]);
                            bus_wdata_q <= mem_wr ? store_data : 32'd0;
                        end
                    end
                end
                STATE_WAIT: begin
                    // An ack on the final counted cycle still completes normally.
                    if (bus_ack) begin
                        state_q     <= STATE_IDLE;
                        bus_req_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_exc_q   <= EXC_NONE;
                        out_data_q  <= bus_we_q ? 32'd0 : load_data;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= STATE_IDLE;
                        bus_req_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_exc_q   <= EXC_TIMEOUT;
                        out_data_q  <= c_q;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= STATE_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == STATE_IDLE);
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_exc   = out_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT=4: pass-through, loads/stores,
// exceptions, timeout boundary and asynchronous reset during a bus wait.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] C;
    logic [31:0] rf_rD2;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  mem_op;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_exc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(4), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .C         (C),
        .rf_rD2    (rf_rD2),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_op    (mem_op),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_exc   (out_exc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] c, input logic [31:0] d,
                         input logic rd, input logic wr, input logic [2:0] op);
        in_valid = 1'b1;
        C        = c;
        rf_rD2   = d;
        mem_rd   = rd;
        mem_wr   = wr;
        mem_op   = op;
        tick();
        in_valid = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] data, input logic [1:0] exc);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " out_data"}, out_data, data);
        chk({tag, " out_exc"}, 32'(out_exc), 32'(exc));
        $display("txn %s: data=%h exc=%0d", tag, out_data, out_exc);
    endtask

    // Issue an aligned load, ack it on the first WAIT cycle, check the extended result.
    task automatic load1(input string tag, input logic [31:0] c, input logic [2:0] op,
                         input logic [31:0] rdata, input logic [31:0] exp);
        issue(c, 32'd0, 1'b1, 1'b0, op);
        chk({tag, " bus_req"}, 32'(bus_req), 32'd1);
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        tick();
        bus_ack   = 1'b0;
        chk_out(tag, exp, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; C = '0; rf_rD2 = '0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_op = 3'b000;
        bus_ack = 1'b0; bus_rdata = '0;
        tick(); tick();
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst bus_req", 32'(bus_req), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", out_data, 32'd0);
        chk("rst out_exc", 32'(out_exc), 32'd0);
        rst_n = 1'b1;
        tick();

        // Pass-through, then back-to-back pass-through
        issue(32'h1234_5678, 32'd0, 1'b0, 1'b0, 3'b010);
        chk_out("pass", 32'h1234_5678, 2'b00);
        chk("pass bus_req", 32'(bus_req), 32'd0);
        tick();
        chk("pass pulse", 32'(out_valid), 32'd0);
        in_valid = 1'b1; C = 32'h0000_0001;
        tick();
        chk_out("b2b0", 32'h0000_0001, 2'b00);
        C = 32'h0000_0002;
        tick();
        in_valid = 1'b0;
        chk_out("b2b1", 32'h0000_0002, 2'b00);

        // LB at 0x103, ack on third WAIT cycle
        issue(32'h0000_0103, 32'd0, 1'b1, 1'b0, 3'b000);
        chk("lb bus_req", 32'(bus_req), 32'd1);
        chk("lb bus_we", 32'(bus_we), 32'd0);
        chk("lb bus_addr", bus_addr, 32'h0000_0100);
        chk("lb bus_be", 32'(bus_be), 32'h8);
        chk("lb in_ready w1", 32'(in_ready), 32'd0);
        tick();
        chk("lb in_ready w2", 32'(in_ready), 32'd0);
        chk("lb out_valid w2", 32'(out_valid), 32'd0);
        tick();
        chk("lb bus_addr w3", bus_addr, 32'h0000_0100);
        bus_ack = 1'b1; bus_rdata = 32'h80AA_BBCC;
        tick();
        bus_ack = 1'b0;
        chk_out("lb", 32'hFFFF_FF80, 2'b00);
        chk("lb bus_req end", 32'(bus_req), 32'd0);
        chk("lb in_ready end", 32'(in_ready), 32'd1);

        // SH at 0x202, ack first WAIT cycle; stray ack afterwards ignored
        issue(32'h0000_0202, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'b001);
        chk("sh bus_we", 32'(bus_we), 32'd1);
        chk("sh bus_be", 32'(bus_be), 32'hC);
        chk("sh bus_wdata", bus_wdata, 32'hBEEF_BEEF);
        chk("sh bus_addr", bus_addr, 32'h0000_0200);
        bus_ack = 1'b1;
        tick();
        chk_out("sh", 32'd0, 2'b00);
        tick();
        bus_ack = 1'b0;
        chk("sh stray ack valid", 32'(out_valid), 32'd0);
        chk("sh stray ack req", 32'(bus_req), 32'd0);

        // SB lane replication
        issue(32'h0000_0101, 32'h1234_565A, 1'b0, 1'b1, 3'b000);
        chk("sb bus_be", 32'(bus_be), 32'h2);
        chk("sb bus_wdata", bus_wdata, 32'h5A5A_5A5A);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk_out("sb", 32'd0, 2'b00);

        // Misaligned and illegal
        issue(32'h0000_0301, 32'd0, 1'b1, 1'b0, 3'b010);
        chk_out("lw mis", 32'h0000_0301, 2'b01);
        chk("lw mis bus_req", 32'(bus_req), 32'd0);
        issue(32'h0000_0203, 32'd0, 1'b1, 1'b0, 3'b101);
        chk_out("lhu mis", 32'h0000_0203, 2'b01);
        issue(32'h0000_0400, 32'd0, 1'b1, 1'b1, 3'b010);
        chk_out("illegal", 32'd0, 2'b11);
        chk("illegal bus_req", 32'(bus_req), 32'd0);

        // Halfword and undefined-op loads
        load1("lh", 32'h0000_0002, 3'b001, 32'h8001_0000, 32'hFFFF_8001);
        load1("lhu", 32'h0000_0002, 3'b101, 32'h8001_0000, 32'h0000_8001);
        load1("op111", 32'h0000_0004, 3'b111, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Timeout: bus_req exactly 4 cycles
        issue(32'h0000_0400, 32'd0, 1'b1, 1'b0, 3'b010);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to req c%0d", i), 32'(bus_req), 32'd1);
            chk($sformatf("to valid c%0d", i), 32'(out_valid), 32'd0);
            tick();
        end
        chk_out("timeout", 32'h0000_0400, 2'b10);
        chk("timeout bus_req", 32'(bus_req), 32'd0);

        // Ack on the 4th WAIT cycle beats the timeout
        issue(32'h0000_0400, 32'd0, 1'b1, 1'b0, 3'b010);
        for (int i = 0; i < 3; i++) tick();
        chk("ack4 req", 32'(bus_req), 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
        tick();
        bus_ack = 1'b0;
        chk_out("ack4", 32'h1122_3344, 2'b00);

        // Asynchronous reset in WAIT
        issue(32'h0000_0000, 32'd0, 1'b1, 1'b0, 3'b100);
        chk("rstw req before", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw req async", 32'(bus_req), 32'd0);
        tick();
        chk("rstw out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rstw out_valid2", 32'(out_valid), 32'd0);
        load1("lbu", 32'h0000_0000, 3'b100, 32'h0000_00F0, 32'h0000_00F0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the execute stage's result path. Takes the ALU result (address or plain result), store data and the memory control bits for one instruction.
- Plain results are registered and passed through. Loads and stores run a single-outstanding req/ack transaction on the data bus, and the stage stalls upstream while it is busy.
- Load data is extracted and sign/zero-extended for writeback. Misaligned accesses and bus timeouts are reported as exceptions.

Parameters:
- TIMEOUT, 255: max cycles waiting for bus_ack before aborting (range 1..255).
- ADDR_W, 32: bus address width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction presented from execute stage
- in_ready  out  1  stage can accept; 0 = stall upstream
- C  in  32  ALU result / effective address
- rf_rD2  in  32  store data
- mem_rd  in  1  instruction is a load
- mem_wr  in  1  instruction is a store
- mem_op  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- bus_req  out  1  transaction request, held until ack
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word-aligned address (C[ADDR_W-1:2], 2'b00)
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  one-cycle completion strobe; rdata valid same cycle
- bus_rdata  in  32  read word
- out_valid  out  1  one-cycle pulse, result ready for writeback
- out_data  out  32  writeback value
- out_exc  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal (rd and wr both set)

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, bus_req=0, out_valid=0, out_data=0, out_exc=0, timeout counter=0, in_ready=1.
  - bus_req deasserts immediately, even mid-transaction; no completion is reported.
- States: IDLE, WAIT.
- in_ready=1 only in IDLE.
- IDLE, in_valid, neither mem_rd nor mem_wr:
  - next cycle out_valid=1, out_data=C, out_exc=00. Latency 1.
- IDLE, in_valid, both mem_rd and mem_wr:
  - next cycle out_valid=1, out_exc=11, out_data=0. No bus activity.
- IDLE, in_valid, access misaligned (H/HU with C[0]=1; W with C[1:0]!=0):
  - next cycle out_valid=1, out_exc=01, out_data=C (faulting address). No bus activity.
- IDLE, in_valid, aligned load/store:
  - register bus_addr, bus_we=mem_wr, bus_be, bus_wdata.
  - next cycle bus_req=1, state WAIT, counter cleared.
- Byte enables and write data:
  - B: be=4'b0001<<C[1:0], wdata={4{rf_rD2[7:0]}}.
  - H: be=4'b0011<<C[1:0], wdata={2{rf_rD2[15:0]}}.
  - W: be=4'b1111, wdata=rf_rD2.
  - Loads drive be the same way; wdata is don't-care (driven 0).
- WAIT, bus signal stability:
  - all bus_* outputs held stable until ack.
  - counter increments each cycle without ack.
- WAIT, bus_ack=1 (including the first WAIT cycle):
  - bus_req=0 next cycle, state IDLE.
  - next cycle out_valid=1, out_exc=00.
  - Load: out_data = lane selected by addr[1:0], sign-extended for B/H, zero-extended for BU/HU.
  - Store: out_data=0.
  - Total load latency = 1 + (cycles to ack) + 1.
- WAIT, counter reaches TIMEOUT-1 with no ack on that cycle:
  - next cycle bus_req=0, state IDLE, out_valid=1, out_exc=10, out_data=C.
  - An ack arriving on that same cycle wins over the timeout.
- bus_ack while IDLE: ignored. bus_ack in the cycle after completion/abort: ignored.
- out_valid is never high on two consecutive cycles for a bus access. Pass-through ops may issue back-to-back, one per cycle.
- Undefined mem_op codes (011, 11x): treated as W.

Decomposition:
- Shared package/defines header holds:
  - MEM_OP_* codes.
  - EXC_* codes.
  - state encodings STATE_IDLE/STATE_WAIT.
- One natural sub-module: load_extend (combinational; mem_op, addr[1:0], rdata -> 32-bit extended value). It is reused by any future cache path.

Test Plan:
- Pass-through: C=0x1234_5678, mem_rd=mem_wr=0 -> out_valid next cycle, out_data=0x1234_5678, no bus_req.
- LB: C=0x103, rdata=0x80AA_BBCC, ack 3 cycles after req -> bus_addr=0x100, be=0001<<3=4'b1000, out_data=0xFFFF_FF80, in_ready low throughout WAIT.
- SH: C=0x202, rD2=0xDEAD_BEEF, ack on first WAIT cycle -> bus_we=1, be=4'b1100, wdata=0xBEEF_BEEF, out_valid 2 cycles after in_valid.
- Misaligned LW at C=0x301 -> out_exc=01, out_data=0x301, bus_req never asserts.
- Timeout with TIMEOUT=4, no ack -> bus_req high exactly 4 cycles, then out_exc=10. Repeat with ack on the 4th cycle -> normal completion.
- Reset asserted during WAIT -> bus_req drops asynchronously, no out_valid. After release, a new LBU at 0x0 with rdata=0x0000_00F0 returns 0x0000_00F0.
